// File: rtl/seg7_scan_driver.sv
// Purpose: multiplexed scan of a common-anode 7-segment display with double-buffered word updates.
// Latency: outputs are registered state only; a loaded word appears from the next frame boundary.
// Backpressure: none; load is always accepted and the last load before a boundary wins.
module seg7_scan_driver #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int REFRESH_HZ  = 1000,
  parameter int NUM_DIGITS  = 4,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [3:0]              bin,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit_idx,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int SLOT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  if (SLOT_CYCLES <= DEAD_CYCLES) begin : g_slot_check
    $error("seg7_scan_driver: SLOT_CYCLES must be greater than DEAD_CYCLES");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_check
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end

  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [4*NUM_DIGITS-1:0]   pend_data;
  logic [NUM_DIGITS-1:0]     pend_en;
  logic                      pend_v;
  logic [4*NUM_DIGITS-1:0]   act_data;
  logic [NUM_DIGITS-1:0]     act_en;

  logic slot_end;
  logic frame_end;
  logic lit;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign lit       = (cnt >= CNT_DEAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pend_data   <= '0;
      pend_en     <= '0;
      pend_v      <= 1'b0;
      act_data    <= '0;
      act_en      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;

      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A load landing on the boundary edge bypasses the pending buffer.
      if (frame_end) begin
        if (load) begin
          act_data <= data;
          act_en   <= digit_en;
          pend_v   <= 1'b0;
        end else if (pend_v) begin
          act_data <= pend_data;
          act_en   <= pend_en;
          pend_v   <= 1'b0;
        end
      end else if (load) begin
        pend_data <= data;
        pend_en   <= digit_en;
        pend_v    <= 1'b1;
      end
    end
  end

  always_comb begin
    bin = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) bin = act_data[4*i +: 4];
    end
  end

  // Anode drops only in the ON phase of its own slot and only when enabled.
  always_comb begin
    an = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx == 3'(j) && lit && act_en[j]) an[j] = 1'b0;
    end
  end

  assign digit_idx = idx;
  assign pending   = pend_v;

endmodule
